dmem_bus_arbiter: RTL and testbench
===================================

// Module: dmem_bus_arbiter
// PURPOSE
//  Owns the shared data-memory port between the CPU and the DMA controller.
//  Implements the BR/BG handshake, inserting one bus-idle turnaround cycle on each ownership change.
//  Muxes address and read/write controls to Memory, and stalls the CPU while it does not own the bus.
//  Sits between cpu, DMA and Memory; replaces the open-coded BG mux at top level.
// PARAMETERS
//  WORD_SIZE   16  data/address width
//  WAIT_LIMIT  4   max cycles a pending BR may wait on CPU traffic before grant is forced (>=1)
// PORTS
//  clk            in   1          system clock, rising edge
//  reset_n        in   1          async active-low reset
//  cpu_d_readM    in   1          CPU data read request
//  cpu_d_writeM   in   1          CPU data write request
//  cpu_d_address  in   WORD_SIZE  CPU data address
//  cpu_wdata      in   WORD_SIZE  CPU write data
//  cpu_rdata      out  WORD_SIZE  read data returned to CPU
//  cpu_stall      out  1          CPU must hold its current memory request
//  BR             in   1          DMA bus request (level; held for the whole transfer)
//  BG             out  1          bus grant to DMA (registered)
//  dma_writeM     in   1          DMA write strobe (valid only while BG=1)
//  dma_addr       in   WORD_SIZE  DMA address
//  dma_wdata      in   WORD_SIZE  DMA write data
//  d_readM        out  1          Memory read
//  d_writeM       out  1          Memory write
//  d_address      out  WORD_SIZE  Memory address
//  d_wdata        out  WORD_SIZE  Memory write data
//  d_rdata        in   WORD_SIZE  Memory read data
// BEHAVIOUR
//  States: CPU_OWN, GRANT_PEND, DMA_OWN, RELEASE. Reset -> CPU_OWN, BG=0, wait_cnt=0.
//  Reset outputs: cpu_stall=0; d_* follow CPU; cpu_rdata=d_rdata.
//  cpu_acc = cpu_d_readM | cpu_d_writeM.
//  CPU_OWN:
//   - BR=1 & !cpu_acc -> DMA_OWN; BG=1 from the next edge (1-cycle grant latency).
//   - BR=1 & cpu_acc -> wait_cnt++; when wait_cnt reaches WAIT_LIMIT-1 -> GRANT_PEND.
//   - BR=0 -> wait_cnt=0.
//  GRANT_PEND (1 cycle): d_readM=d_writeM=0, cpu_stall=1, BG=0.
//   - BR=1 -> DMA_OWN; BR=0 -> CPU_OWN (request withdrawn).
//  DMA_OWN:
//   - BG=1; d_writeM=dma_writeM; d_readM=0; d_address=dma_addr; d_wdata=dma_wdata.
//   - cpu_stall=cpu_acc; cpu_rdata=0.
//   - BR=0 -> RELEASE, with BG=0 from that edge.
//  RELEASE (1 cycle): all d_* controls 0, cpu_stall=cpu_acc, BG=0 -> CPU_OWN.
//   - A new BR during RELEASE is honoured from CPU_OWN next cycle; no back-to-back grant.
//  CPU_OWN muxing: d_* = cpu_*; cpu_stall=0.
//  Mux outputs are combinational from state. Only state, BG and wait_cnt are registered.
//  wait_cnt width: $clog2(WAIT_LIMIT)+1; cleared on every grant.
//  Invariant: d_readM and d_writeM are never both 1. The DMA never drives memory while BG=0.
//  Reset mid-transfer: BG drops asynchronously; the DMA must abort. No pending state survives reset.
//  BR rising in the same cycle the CPU finishes an access: cpu_acc is sampled at that edge, so an access still active at the edge defers the grant.
// STRUCTURE
//  Shared package/include: WORD_SIZE define; ARB_* state encodings (2-bit localparams).
//  Single flat module; no sub-module. The top level instantiates it in place of the BG-based assigns.
// TESTING
//  1. Reset held, BR=1 -> BG=0, d_* mirror CPU; release reset with CPU idle -> BG=1 one edge later.
//  2. CPU idle, BR pulse for 4 cycles with dma_addr 0x01F4..0x01F7, writes -> 4 Memory writes, then 1 RELEASE cycle with d_writeM=0, then CPU_OWN.
//  3. CPU reading every cycle, BR=1, WAIT_LIMIT=4 -> GRANT_PEND entered after 3 waited cycles (cpu_stall=1), BG=1 on the following edge.
//  4. BR drops during GRANT_PEND -> BG never asserted; return to CPU_OWN with cpu_stall=0.
//  5. CPU write to 0x0010 issued while BG=1 -> cpu_stall=1 and no CPU write reaches Memory; write proceeds 2 cycles after BR drops.
//  6. reset_n low mid-DMA -> BG=0 immediately (async), d_writeM=0, state CPU_OWN.

Source files
------------

// File: rtl/dmem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_bus_arbiter_pkg
//   Shared definitions for the data-memory bus arbiter:
//     DMEM_WORD_SIZE  - default data/address width of the data-memory port
//     ARB_WAIT_LIMIT  - default number of cycles a DMA request may wait on CPU
//                       traffic before the grant is forced
//     arb_state_e     - 2-bit ownership state encodings (ARB_*)
// -----------------------------------------------------------------------------
package dmem_bus_arbiter_pkg;

  localparam int DMEM_WORD_SIZE = 16;
  localparam int ARB_WAIT_LIMIT = 4;

  typedef enum logic [1:0] {
    ARB_CPU_OWN    = 2'b00,  // CPU drives the memory port
    ARB_GRANT_PEND = 2'b01,  // forced turnaround before handing the bus to DMA
    ARB_DMA_OWN    = 2'b10,  // DMA drives the memory port, BG asserted
    ARB_RELEASE    = 2'b11   // turnaround after DMA hands the bus back
  } arb_state_e;

endpackage : dmem_bus_arbiter_pkg

// File: rtl/dmem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_bus_arbiter
//   Owns the shared data-memory port between the CPU and the DMA controller.
//   Implements the BR/BG handshake with one bus-idle turnaround cycle on every
//   ownership change, muxes address/data/controls to memory, and stalls the
//   CPU while it does not own the bus.
//
// Ports
//   clk, reset_n                    clock (rising edge), async active-low reset
//   cpu_d_readM / cpu_d_writeM      CPU data read / write request
//   cpu_d_address / cpu_wdata       CPU address / write data
//   cpu_rdata                       read data returned to the CPU
//   cpu_stall                       CPU must hold its current request
//   BR / BG                         DMA bus request (level) / registered grant
//   dma_writeM, dma_addr, dma_wdata DMA write strobe, address, write data
//   d_readM, d_writeM               memory read / write strobes
//   d_address, d_wdata, d_rdata     memory address, write data, read data
// -----------------------------------------------------------------------------
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE  = DMEM_WORD_SIZE,
  parameter int WAIT_LIMIT = ARB_WAIT_LIMIT   // must be >= 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_d_readM,
  input  logic                 cpu_d_writeM,
  input  logic [WORD_SIZE-1:0] cpu_d_address,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 BR,
  output logic                 BG,
  input  logic                 dma_writeM,
  input  logic [WORD_SIZE-1:0] dma_addr,
  input  logic [WORD_SIZE-1:0] dma_wdata,
  output logic                 d_readM,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  output logic [WORD_SIZE-1:0] d_wdata,
  input  logic [WORD_SIZE-1:0] d_rdata
);

  localparam int CW = $clog2(WAIT_LIMIT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

  arb_state_e    state_q, state_d;
  logic          bg_q, bg_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] wait_inc;
  logic          cpu_acc;

  assign cpu_acc  = cpu_d_readM | cpu_d_writeM;
  assign wait_inc = wait_cnt_q + CW'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      ARB_CPU_OWN: begin
        if (!BR) begin
          wait_cnt_d = '0;
        end else if (!cpu_acc) begin
          // Bus is quiet: hand it over directly, the idle cycle is this one.
          state_d    = ARB_DMA_OWN;
          wait_cnt_d = '0;
        end else if (wait_inc >= WAIT_LAST) begin
          // CPU has held the bus long enough; force a turnaround.
          state_d    = ARB_GRANT_PEND;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      ARB_GRANT_PEND: begin
        wait_cnt_d = '0;
        state_d    = BR ? ARB_DMA_OWN : ARB_CPU_OWN;
      end
      ARB_DMA_OWN: begin
        state_d = BR ? ARB_DMA_OWN : ARB_RELEASE;
      end
      ARB_RELEASE: begin
        // A BR seen here is re-evaluated from CPU_OWN; never grant back-to-back.
        state_d = ARB_CPU_OWN;
      end
      default: begin
        state_d    = ARB_CPU_OWN;
        wait_cnt_d = '0;
      end
    endcase

    // BG is a registered copy of "DMA will own the bus next cycle".
    bg_d = (state_d == ARB_DMA_OWN);
  end

  // ---------------------------------------------------------------------------
  // Output muxing, combinational from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    d_readM   = cpu_d_readM;
    d_writeM  = cpu_d_writeM;
    d_address = cpu_d_address;
    d_wdata   = cpu_wdata;
    cpu_rdata = d_rdata;
    cpu_stall = 1'b0;

    unique case (state_q)
      ARB_CPU_OWN: ;
      ARB_GRANT_PEND: begin
        d_readM   = 1'b0;
        d_writeM  = 1'b0;
        cpu_stall = 1'b1;
      end
      ARB_DMA_OWN: begin
        d_readM   = 1'b0;
        // Gated by the grant so the DMA can never write an ungranted bus.
        d_writeM  = dma_writeM & bg_q;
        d_address = dma_addr;
        d_wdata   = dma_wdata;
        cpu_rdata = '0;
        cpu_stall = cpu_acc;
      end
      ARB_RELEASE: begin
        d_readM   = 1'b0;
        d_writeM  = 1'b0;
        cpu_stall = cpu_acc;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the async reset drops BG immediately so a DMA mid-transfer aborts;
  // nothing from a pending request survives reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_CPU_OWN;
      bg_q       <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bg_q       <= bg_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign BG = bg_q;

endmodule : dmem_bus_arbiter

// File: tb/tb_dmem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_arbiter
//   Directed bench for dmem_bus_arbiter (WORD_SIZE=16, WAIT_LIMIT=4).
//   Each step drives inputs just after a rising edge, pushes the expected
//   output set to a scoreboard queue, and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_bus_arbiter;

  localparam int W = 16;

  typedef struct packed {
    logic         bg;
    logic         stall;
    logic         rd;
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
    obs_t  mask;
  } sb_t;

  localparam obs_t MASK_ALL  = '1;
  localparam obs_t MASK_CTRL = {4'b1111, {(3*W){1'b0}}};

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cpu_rd, cpu_wr;
  logic [W-1:0] cpu_addr, cpu_wd;
  logic [W-1:0] cpu_rdata;
  logic         cpu_stall;
  logic         br, bg;
  logic         dma_wr;
  logic [W-1:0] dma_addr, dma_wd;
  logic         d_readM, d_writeM;
  logic [W-1:0] d_address, d_wdata;
  logic [W-1:0] mem_rdata;

  int  n_assert = 0;
  int  n_fail   = 0;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  dmem_bus_arbiter #(.WORD_SIZE(W), .WAIT_LIMIT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_d_readM  (cpu_rd),
    .cpu_d_writeM (cpu_wr),
    .cpu_d_address(cpu_addr),
    .cpu_wdata    (cpu_wd),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .BR           (br),
    .BG           (bg),
    .dma_writeM   (dma_wr),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wd),
    .d_readM      (d_readM),
    .d_writeM     (d_writeM),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (mem_rdata)
  );

  // Expected output sets, built from the bench's own stimulus.
  function automatic obs_t e_cpu();
    return '{bg: 1'b0, stall: 1'b0, rd: cpu_rd, wr: cpu_wr,
             addr: cpu_addr, wdata: cpu_wd, rdata: mem_rdata};
  endfunction

  function automatic obs_t e_dma();
    return '{bg: 1'b1, stall: cpu_rd | cpu_wr, rd: 1'b0, wr: dma_wr,
             addr: dma_addr, wdata: dma_wd, rdata: '0};
  endfunction

  function automatic obs_t e_turn(input logic stall);
    return '{bg: 1'b0, stall: stall, rd: 1'b0, wr: 1'b0,
             addr: '0, wdata: '0, rdata: '0};
  endfunction

  function automatic obs_t observed();
    return '{bg: bg, stall: cpu_stall, rd: d_readM, wr: d_writeM,
             addr: d_address, wdata: d_wdata, rdata: cpu_rdata};
  endfunction

  task automatic compare_head();
    sb_t  s;
    obs_t o;
    s = sb_q.pop_front();
    o = observed();
    n_assert++;
    assert ((o & s.mask) === (s.exp & s.mask))
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (mask %h)", s.tag, o, s.exp, s.mask);
    end
  endtask

  // Push expectation, compare on the falling edge, return just after next rise.
  task automatic chk(input string tag, input obs_t e, input obs_t m);
    sb_q.push_back('{tag: tag, exp: e, mask: m});
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  // Compare without waiting for a clock edge (asynchronous behaviour).
  task automatic chk_now(input string tag, input obs_t e, input obs_t m);
    sb_q.push_back('{tag: tag, exp: e, mask: m});
    #1;
    compare_head();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = 16'h0100;
    cpu_wd    = 16'h1111;
    br        = 1'b1;
    dma_wr    = 1'b0;
    dma_addr  = 16'h0000;
    dma_wd    = 16'h0000;
    mem_rdata = 16'h1234;

    // 1. Reset held with BR=1: no grant, memory port mirrors the CPU.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_idle", e_cpu(), MASK_ALL);
    cpu_rd = 1'b1; cpu_addr = 16'h0104;
    chk("rst_hold_read", e_cpu(), MASK_ALL);
    cpu_rd = 1'b0;
    reset_n = 1'b1;
    chk("rst_release", e_cpu(), MASK_ALL);
    dma_addr = 16'h0AAA; dma_wd = 16'h5555;
    chk("grant_after_rst", e_dma(), MASK_ALL);
    br = 1'b0;
    chk("grant_last", e_dma(), MASK_ALL);
    chk("release_1", e_turn(1'b0), MASK_CTRL);
    chk("cpu_back_1", e_cpu(), MASK_ALL);

    // 2. Four-cycle DMA write burst to 0x01F4..0x01F7 with CPU idle.
    br = 1'b1; dma_wr = 1'b1; dma_addr = 16'h01F4; dma_wd = 16'hD000;
    chk("burst_req", e_cpu(), MASK_ALL);
    for (int i = 0; i < 4; i++) begin
      dma_addr = 16'h01F4 + 16'(i);
      dma_wd   = 16'hD000 + 16'(i);
      if (i == 3) br = 1'b0;
      chk($sformatf("burst_wr%0d", i), e_dma(), MASK_ALL);
    end
    chk("burst_release", e_turn(1'b0), MASK_CTRL);
    dma_wr = 1'b0;
    chk("burst_cpu_back", e_cpu(), MASK_ALL);

    // 3. CPU reads every cycle; grant forced after 3 waited cycles.
    cpu_rd = 1'b1; cpu_addr = 16'h0200; mem_rdata = 16'h00C3; br = 1'b1;
    dma_addr = 16'h0300; dma_wd = 16'h7777;
    for (int i = 0; i < 3; i++) chk($sformatf("force_wait%0d", i), e_cpu(), MASK_ALL);
    chk("force_pend", e_turn(1'b1), MASK_CTRL);
    chk("force_grant", e_dma(), MASK_ALL);
    br = 1'b0;
    chk("force_last", e_dma(), MASK_ALL);
    chk("force_release", e_turn(1'b1), MASK_CTRL);
    chk("force_cpu_back", e_cpu(), MASK_ALL);

    // 4. BR withdrawn during GRANT_PEND: BG never asserted.
    cpu_addr = 16'h0204; mem_rdata = 16'h4321; br = 1'b1;
    for (int i = 0; i < 3; i++) chk($sformatf("wd_wait%0d", i), e_cpu(), MASK_ALL);
    br = 1'b0;
    chk("wd_pend", e_turn(1'b1), MASK_CTRL);
    chk("wd_cpu_back", e_cpu(), MASK_ALL);
    cpu_rd = 1'b0;
    chk("wd_no_grant", e_cpu(), MASK_ALL);

    // 5. CPU write to 0x0010 while DMA owns the bus: held off until CPU_OWN.
    br = 1'b1; dma_wr = 1'b0; dma_addr = 16'h0400; dma_wd = 16'h0000;
    chk("cw_req", e_cpu(), MASK_ALL);
    cpu_wr = 1'b1; cpu_addr = 16'h0010; cpu_wd = 16'hCAFE;
    chk("cw_stall0", e_dma(), MASK_ALL);
    chk("cw_stall1", e_dma(), MASK_ALL);
    br = 1'b0;
    chk("cw_br_drop", e_dma(), MASK_ALL);
    chk("cw_release", e_turn(1'b1), MASK_CTRL);
    chk("cw_write", e_cpu(), MASK_ALL);
    cpu_wr = 1'b0;

    // 6. Asynchronous reset in the middle of a DMA write.
    br = 1'b1; dma_wr = 1'b1; dma_addr = 16'h0500; dma_wd = 16'hBEEF;
    chk("ar_req", e_cpu(), MASK_ALL);
    chk("ar_dma", e_dma(), MASK_ALL);
    #2;
    reset_n = 1'b0;
    chk_now("ar_async", e_cpu(), MASK_ALL);
    chk("ar_held", e_cpu(), MASK_ALL);
    br = 1'b0; dma_wr = 1'b0;
    reset_n = 1'b1;
    chk("ar_released", e_cpu(), MASK_ALL);
    chk("ar_cpu_own", e_cpu(), MASK_ALL);

    if (sb_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_dmem_bus_arbiter
